instr_fetch: RTL and testbench

- Fetch stage of the RISC-V core. Sits directly upstream of the control/decode logic and supplies the instruction word and its PC to it.
- Maintains the fetch PC and issues requests to instruction memory through a request/response handshake.
- Buffers returned words in a small FIFO.
- On a taken branch/jump (pc_sel_i from control logic), redirects to pc_target_i and squashes in-flight fetches.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/instr_fetch.sv | 176 +++++++++++++++++
 tb/tb_instr_fetch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the fetch stage: default NOP word, control-flow
// opcodes and the PC-tagged instruction entry carried through the fetch buffer.
package riscv_pkg;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic is_ctrl_flow(input logic [31:0] inst);
    return (inst[6:0] == OP_BRANCH) || (inst[6:0] == OP_JAL) || (inst[6:0] == OP_JALR);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of PC-tagged instruction words with push, pop,
// flush and an occupancy count; flush wins over push and pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_COUNT) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + (AW + 1)'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// RISC-V fetch stage: credit-limited imem requests, PC-tagged response buffering,
// redirect with squash. Optional counters enabled by `define INSTR_FETCH_PERF_EN.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        pc_sel_i,
  input  logic [31:0] pc_target_i,
  input  logic        stall_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0] fetched_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   pc_q, pc_d;
  logic          inst_valid_q, inst_valid_d;

  fetch_entry_t  fifo_head;
  fetch_entry_t  resp_entry;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_push, fifo_pop;
  logic [CW:0]   in_flight;
  logic          accept, resp, resp_keep, load_valid;
  logic          unused_target_bits;

  assign unused_target_bits = ^pc_target_i[1:0];

  assign in_flight   = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req_o  = !rst && (in_flight < (CW + 1)'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc_q;
  assign accept      = imem_req_o && imem_ready_i;

  // Responses with nothing outstanding are stray and ignored entirely.
  assign resp      = imem_rvalid_i && (outstanding_q != '0);
  assign resp_keep = resp && (drop_q == '0) && !pc_sel_i;

  // Non-squashed fetches are contiguous and end at fetch_pc, so the oldest one
  // sits outstanding words behind it.
  assign resp_entry.pc   = fetch_pc_q - {{(30 - CW){1'b0}}, outstanding_q, 2'b00};
  assign resp_entry.inst = imem_rdata_i;

  assign fifo_pop   = !pc_sel_i && !stall_i && !fifo_empty;
  assign fifo_push  = resp_keep && !(!stall_i && fifo_empty);
  assign load_valid = !pc_sel_i && !stall_i && (!fifo_empty || resp_keep);

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (resp_entry),
    .pop_i       (fifo_pop),
    .flush_i     (pc_sel_i),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    inst_d        = inst_q;
    pc_d          = pc_q;
    inst_valid_d  = inst_valid_q;

    if (accept) begin
      fetch_pc_d    = fetch_pc_q + 32'd4;
      outstanding_d = outstanding_d + CW'(1);
    end
    if (resp) begin
      outstanding_d = outstanding_d - CW'(1);
      if (drop_q != '0) begin
        drop_d = drop_q - CW'(1);
      end
    end

    // Redirect squashes everything still in flight, including this cycle's accept.
    if (pc_sel_i) begin
      fetch_pc_d   = {pc_target_i[31:2], 2'b00};
      drop_d       = outstanding_d;
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
    end else if (!stall_i) begin
      if (!fifo_empty) begin
        inst_d       = fifo_head.inst;
        pc_d         = fifo_head.pc;
        inst_valid_d = 1'b1;
      end else if (resp_keep) begin
        inst_d       = resp_entry.inst;
        pc_d         = resp_entry.pc;
        inst_valid_d = 1'b1;
      end else begin
        inst_d       = NOP_INST;
        inst_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      inst_q        <= NOP_INST;
      pc_q          <= '0;
      inst_valid_q  <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      inst_q        <= inst_d;
      pc_q          <= pc_d;
      inst_valid_q  <= inst_valid_d;
    end
  end

  assign inst_o       = inst_q;
  assign pc_o         = pc_q;
  assign inst_valid_o = inst_valid_q;

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] fetched_cnt_q, fetched_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetched_cnt_d = fetched_cnt_q;
    bubble_cnt_d  = bubble_cnt_q;
    if (load_valid) begin
      fetched_cnt_d = fetched_cnt_q + 32'd1;
    end else if (!stall_i) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_cnt_q <= '0;
      bubble_cnt_q  <= '0;
    end else begin
      fetched_cnt_q <= fetched_cnt_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  assign fetched_cnt_o = fetched_cnt_q;
  assign bubble_cnt_o  = bubble_cnt_q;
`else
  logic unused_load_valid;
  assign unused_load_valid = load_valid;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: in-order memory responder plus a linear
// sequence of hand-computed checks (fetch stream, stall, redirects, reset).
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        pc_sel_i;
  logic [31:0] pc_target_i;
  logic        stall_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;

  logic        release_rsp;
  logic        seen;
  logic [31:0] held_addr;
  int          tests = 0;
  int          fails = 0;

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_sel_i      (pc_sel_i),
    .pc_target_i   (pc_target_i),
    .stall_i       (stall_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .inst_valid_o  (inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h00A0_0093 + (a << 8);
  endfunction

  // Memory model: in-order queue of accepted addresses, one response per cycle
  // while release_rsp is high, visible at the edge after acceptance at the earliest.
  initial begin
    logic [31:0] pend_q[$];
    logic        acc;
    logic [31:0] acc_addr;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(posedge clk);
      acc      = imem_req_o && imem_ready_i;
      acc_addr = imem_addr_o;
      #1;
      if (rst) pend_q.delete();
      else if (acc) pend_q.push_back(acc_addr);
      if (release_rsp && pend_q.size() > 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = memWord(pend_q.pop_front());
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic r, input logic rdy, input logic sel,
                               input logic stl, input logic [31:0] tgt);
    rst          = r;
    imem_ready_i = rdy;
    pc_sel_i     = sel;
    stall_i      = stl;
    pc_target_i  = tgt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic waitValid(input int maxCycles, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (inst_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    release_rsp = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_req", {31'b0, imem_req_o}, 32'd0);
    checkOutput("rst_addr", imem_addr_o, 32'h0);
    checkOutput("rst_inst", inst_o, NOP);
    checkOutput("rst_pc", pc_o, 32'h0);
    checkOutput("rst_valid", {31'b0, inst_valid_o}, 32'd0);

    // 1: sequential fetch, one-cycle memory
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("t1_req0", {31'b0, imem_req_o}, 32'd1);
    checkOutput("t1_addr0", imem_addr_o, 32'h0);
    @(negedge clk);
    checkOutput("t1_addr1", imem_addr_o, 32'h4);
    checkOutput("t1_valid1", {31'b0, inst_valid_o}, 32'd0);
    @(negedge clk);
    checkOutput("t1_addr2", imem_addr_o, 32'h8);
    checkOutput("t1_valid2", {31'b0, inst_valid_o}, 32'd1);
    checkOutput("t1_pc2", pc_o, 32'h0);
    checkOutput("t1_inst2", inst_o, 32'h00A0_0093);
    @(negedge clk);
    checkOutput("t1_pc3", pc_o, 32'h4);
    checkOutput("t1_inst3", inst_o, memWord(32'h4));
    @(negedge clk);
    checkOutput("t1_pc4", pc_o, 32'h8);
    checkOutput("t1_inst4", inst_o, memWord(32'h8));
    checkOutput("t1_addr4", imem_addr_o, 32'h10);

    // 2: four-cycle stall fills the buffer and throttles requests
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    checkOutput("t2_req_full", {31'b0, imem_req_o}, 32'd0);
    checkOutput("t2_pc_hold", pc_o, 32'h8);
    checkOutput("t2_inst_hold", inst_o, memWord(32'h8));
    repeat (3) @(negedge clk);
    checkOutput("t2_req_still", {31'b0, imem_req_o}, 32'd0);
    checkOutput("t2_pc_hold_end", pc_o, 32'h8);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t2_pc_c", pc_o, 32'hC);
    checkOutput("t2_inst_c", inst_o, memWord(32'hC));
    checkOutput("t2_req_resume", {31'b0, imem_req_o}, 32'd1);
    checkOutput("t2_addr_resume", imem_addr_o, 32'h14);
    @(negedge clk);
    checkOutput("t2_pc_10", pc_o, 32'h10);
    @(negedge clk);
    checkOutput("t2_pc_14", pc_o, 32'h14);
    checkOutput("t2_inst_14", inst_o, memWord(32'h14));

    // 3: two fetches held outstanding, then redirect to 0x100
    release_rsp = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t3_req_credit", {31'b0, imem_req_o}, 32'd0);
    checkOutput("t3_bubble_valid", {31'b0, inst_valid_o}, 32'd0);
    checkOutput("t3_bubble_inst", inst_o, NOP);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h100);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    release_rsp = 1'b1;
    checkOutput("t3_addr", imem_addr_o, 32'h100);
    checkOutput("t3_valid_off", {31'b0, inst_valid_o}, 32'd0);
    waitValid(10, seen);
    checkOutput("t3_seen", {31'b0, seen}, 32'd1);
    checkOutput("t3_first_pc", pc_o, 32'h100);
    checkOutput("t3_first_inst", inst_o, memWord(32'h100));

    // 4: misaligned target is word aligned
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0203);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t4_addr_align", imem_addr_o, 32'h200);
    checkOutput("t4_inst_nop", inst_o, NOP);
    waitValid(10, seen);
    checkOutput("t4_seen", {31'b0, seen}, 32'd1);
    checkOutput("t4_first_pc", pc_o, 32'h200);

    // 5: redirect coincides with a response while stalled
    for (int i = 0; i < 4 && imem_rvalid_i !== 1'b1; i++) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h300);
    @(negedge clk);
    checkOutput("t5_inst_nop", inst_o, NOP);
    checkOutput("t5_valid_off", {31'b0, inst_valid_o}, 32'd0);
    checkOutput("t5_addr", imem_addr_o, 32'h300);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    waitValid(10, seen);
    checkOutput("t5_seen", {31'b0, seen}, 32'd1);
    checkOutput("t5_first_pc", pc_o, 32'h300);
    checkOutput("t5_first_inst", inst_o, memWord(32'h300));

    // 6: memory not ready for five cycles, then reset mid-stream
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    held_addr = imem_addr_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t6_req_pending", {31'b0, imem_req_o}, 32'd1);
      checkOutput("t6_addr_stable", imem_addr_o, held_addr);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t6_addr_advance", imem_addr_o, held_addr + 32'd4);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t6_rst_addr", imem_addr_o, 32'h0);
    checkOutput("t6_rst_valid", {31'b0, inst_valid_o}, 32'd0);
    checkOutput("t6_rst_req", {31'b0, imem_req_o}, 32'd0);
    checkOutput("t6_rst_pc", pc_o, 32'h0);
    checkOutput("t6_rst_inst", inst_o, NOP);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    waitValid(10, seen);
    checkOutput("t6_seen", {31'b0, seen}, 32'd1);
    checkOutput("t6_first_pc", pc_o, 32'h0);
    checkOutput("t6_first_inst", inst_o, memWord(32'h0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
